// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings: opcodes, multicycle FSM states and ALU operation codes.
package mips_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALTED = 3'b101
  } state_e;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_JUMP = 4'b0100;
  localparam logic [3:0] OP_ORI  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_ANDI = 4'b0111;
  localparam logic [3:0] OP_SLTI = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Opcodes 1001..1110 are reserved; HALT is defined but never enters EXEC.
  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_SLTI) || (op == OP_HALT);
  endfunction

  function automatic logic op_uses_imm(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW, OP_ORI, OP_ANDI, OP_ADDI, OP_SLTI: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps an instruction opcode to the ALU operation code used during execution.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (op_i)
      OP_R:                       alu_op_o = ALU_FUNCT;
      OP_BEQ:                     alu_op_o = ALU_SUB;
      OP_ORI:                     alu_op_o = ALU_OR;
      OP_ANDI:                    alu_op_o = ALU_AND;
      OP_SLTI:                    alu_op_o = ALU_SLT;
      OP_LW, OP_SW, OP_ADDI, OP_JUMP: alu_op_o = ALU_ADD;
      default:                    alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM; outputs decode from current state and the opcode latched in DECODE.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opCode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       aluSrc,
  output logic       regWrite,
  output logic [3:0] aluOp,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] dec_alu_op;

  alu_op_decode u_alu_op_decode (
    .op_i     (opcode_q),
    .alu_op_o (dec_alu_op)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    pcWrite  = 1'b0;
    pcSrc    = PC_INC;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    regWrite = 1'b0;
    aluOp    = 4'b0000;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      // Branch on the live opcode here; later states see only the latched copy.
      S_DECODE: begin
        opcode_d = opCode;
        if (opCode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (!op_defined(opCode)) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluOp  = dec_alu_op;
        aluSrc = op_uses_imm(opcode_q);
        case (opcode_q)
          OP_BEQ: begin
            pcWrite = zero;
            pcSrc   = PC_BRANCH;
            state_d = S_FETCH;
          end
          OP_JUMP: begin
            pcWrite = 1'b1;
            pcSrc   = PC_JUMP;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (opcode_q == OP_SW) begin
          memWrite = 1'b1;
        end else begin
          memRead = 1'b1;
        end
        if (memReady) begin
          state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = (opcode_q == OP_R);
        memToReg = (opcode_q == OP_LW);
        state_d  = S_FETCH;
      end
      S_HALTED: begin
        halted  = 1'b1;
        state_d = S_HALTED;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-cycle vector table plus HALT and reset-in-MEM sequences, via an expected-value queue.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset, zero, memReady;
  logic [3:0] opCode;
  logic       pcWrite, irWrite, memRead, memWrite, memToReg, regDst, aluSrc, regWrite;
  logic       halted, illegal;
  logic [1:0] pcSrc;
  logic [3:0] aluOp;
  logic [2:0] state;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .irWrite(irWrite), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst), .aluSrc(aluSrc),
    .regWrite(regWrite), .aluOp(aluOp), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  // {state, pcWrite, pcSrc, irWrite, memRead, memWrite, memToReg, regDst, aluSrc, regWrite, aluOp, halted, illegal}
  typedef logic [18:0] out_t;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       z;
    logic       mr;
    out_t       e;
    string      nm;
  } vec_t;

  vec_t  vecs[$];
  out_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic out_t mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                              input logic irw, input logic mrd, input logic mwr, input logic m2r,
                              input logic rdst, input logic asrc, input logic rw,
                              input logic [3:0] aop, input logic hlt, input logic ill);
    return {st, pcw, pcs, irw, mrd, mwr, m2r, rdst, asrc, rw, aop, hlt, ill};
  endfunction

  out_t F_WAIT, F_GO, DEC, HLT;

  task automatic add(input logic rst, input logic [3:0] op, input logic z, input logic mr,
                     input out_t e, input string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.e = e; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge, then compare the combinational outputs.
  task automatic cyc(input logic rst, input logic [3:0] op, input logic z, input logic mr,
                     input out_t e, input string nm);
    out_t  got, want;
    string n;
    @(negedge clock);
    reset = rst; opCode = op; zero = z; memReady = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    got  = {state, pcWrite, pcSrc, irWrite, memRead, memWrite, memToReg, regDst, aluSrc,
            regWrite, aluOp, halted, illegal};
    want = exp_q.pop_front();
    n    = name_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, want);
    end
  endtask

  task automatic add_wb_op(input logic [3:0] op, input logic [3:0] aop, input logic asrc,
                           input logic rdst, input string nm);
    add(1'b0, op,      1'b0, 1'b1, F_GO, {nm, "_fetch"});
    add(1'b0, op,      1'b0, 1'b0, DEC,  {nm, "_decode"});
    add(1'b0, 4'b1001, 1'b0, 1'b0, mk(3'b010,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,asrc,1'b0,aop,1'b0,1'b0), {nm, "_exec"});
    add(1'b0, 4'b1111, 1'b0, 1'b0, mk(3'b100,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,rdst,1'b0,1'b1,4'b0000,1'b0,1'b0), {nm, "_wb"});
  endtask

  initial begin
    F_WAIT = mk(3'b000,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0);
    F_GO   = mk(3'b000,1'b1,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0);
    DEC    = mk(3'b001,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0);
    HLT    = mk(3'b101,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b0);

    reset = 1'b1; opCode = 4'b0000; zero = 1'b0; memReady = 1'b0;
    @(posedge clock);
    @(posedge clock);

    add(1'b0, 4'b0000, 1'b0, 1'b0, F_WAIT, "reset_fetch");
    add_wb_op(4'b0110, 4'b0000, 1'b1, 1'b0, "addi");
    add(1'b0, 4'b0000, 1'b0, 1'b0, F_WAIT, "addi_back_fetch");
    // LW with two wait cycles in MEM.
    add(1'b0, 4'b0001, 1'b0, 1'b1, F_GO, "lw_fetch");
    add(1'b0, 4'b0001, 1'b0, 1'b0, DEC,  "lw_decode");
    add(1'b0, 4'b1010, 1'b0, 1'b1, mk(3'b010,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0,1'b0), "lw_exec");
    add(1'b0, 4'b1010, 1'b0, 1'b0, mk(3'b011,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "lw_mem0");
    add(1'b0, 4'b0011, 1'b0, 1'b0, mk(3'b011,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "lw_mem1");
    add(1'b0, 4'b0011, 1'b0, 1'b1, mk(3'b011,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "lw_mem2");
    add(1'b0, 4'b0011, 1'b0, 1'b0, mk(3'b100,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,4'b0000,1'b0,1'b0), "lw_wb");
    // BEQ taken then not taken.
    add(1'b0, 4'b0010, 1'b0, 1'b1, F_GO, "beq1_fetch");
    add(1'b0, 4'b0010, 1'b0, 1'b0, DEC,  "beq1_decode");
    add(1'b0, 4'b0000, 1'b1, 1'b0, mk(3'b010,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0), "beq1_exec");
    add(1'b0, 4'b0010, 1'b0, 1'b1, F_GO, "beq0_fetch");
    add(1'b0, 4'b0010, 1'b1, 1'b1, DEC,  "beq0_decode");
    add(1'b0, 4'b0000, 1'b0, 1'b0, mk(3'b010,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0), "beq0_exec");
    // Undefined opcode: two cycles, illegal pulse only in DECODE.
    add(1'b0, 4'b1010, 1'b0, 1'b1, F_GO, "ill_fetch");
    add(1'b0, 4'b1010, 1'b0, 1'b0, mk(3'b001,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b1), "ill_decode");
    add(1'b0, 4'b1010, 1'b0, 1'b0, F_WAIT, "ill_back_fetch");
    add(1'b0, 4'b0100, 1'b0, 1'b1, F_GO, "jump_fetch");
    add(1'b0, 4'b0100, 1'b0, 1'b0, DEC,  "jump_decode");
    add(1'b0, 4'b0010, 1'b0, 1'b0, mk(3'b010,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "jump_exec");
    add_wb_op(4'b0000, 4'b0010, 1'b0, 1'b1, "rtype");
    add(1'b0, 4'b0011, 1'b0, 1'b1, F_GO, "sw_fetch");
    add(1'b0, 4'b0011, 1'b0, 1'b0, DEC,  "sw_decode");
    add(1'b0, 4'b0001, 1'b0, 1'b0, mk(3'b010,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0,1'b0), "sw_exec");
    add(1'b0, 4'b0001, 1'b0, 1'b1, mk(3'b011,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "sw_mem");
    add_wb_op(4'b0101, 4'b0011, 1'b1, 1'b0, "ori");
    add_wb_op(4'b0111, 4'b0100, 1'b1, 1'b0, "andi");
    add_wb_op(4'b1000, 4'b0101, 1'b1, 1'b0, "slti");
    add(1'b0, 4'b0000, 1'b0, 1'b0, F_WAIT, "final_fetch");

    foreach (vecs[i]) cyc(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].e, vecs[i].nm);

    // HALT is sticky regardless of inputs until reset.
    cyc(1'b0, 4'b1111, 1'b0, 1'b1, F_GO, "halt_fetch");
    cyc(1'b0, 4'b1111, 1'b0, 1'b0, DEC,  "halt_decode");
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), HLT, "halted_hold");
    end
    cyc(1'b1, 4'b0000, 1'b0, 1'b1, HLT,    "halt_reset_cycle");
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, F_WAIT, "halt_after_reset");

    // Reset while SW waits in MEM.
    cyc(1'b0, 4'b0011, 1'b0, 1'b1, F_GO, "swr_fetch");
    cyc(1'b0, 4'b0011, 1'b0, 1'b0, DEC,  "swr_decode");
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, mk(3'b010,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0,1'b0), "swr_exec");
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, mk(3'b011,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "swr_mem_wait");
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, mk(3'b011,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0), "swr_reset_cycle");
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, F_WAIT, "swr_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
